fc_seq_ctrl_param_2: RTL

Layer sequencer for the fully-connected stage of CNN layer 2. On a start pulse it steps through OUTNEURON/PO output groups. For each group it:
- enables the FC address generator for exactly one input sweep,
- issues time-aligned accumulator clear/enable strobes matched to the address+BRAM pipeline latency,
- presents a valid/ready result handshake to the writeback stage.
It sits between the layer-level control and the FC address generator, weight/input BRAMs and MAC array.

---
 rtl/fc_seq_ctrl_param_2_pkg.sv | 30 +++
 rtl/fc_seq_ctrl_param_2_if.sv | 42 ++++
 rtl/fc_delay_line_param_2.sv | 32 +++
 rtl/fc_seq_ctrl_param_2.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/fc_seq_ctrl_param_2_pkg.sv
// Shared types and default layer geometry for the layer-2 fully-connected sequencer.
package fc_seq_ctrl_param_2_pkg;

   localparam int DEF_INNEURON  = 256;
   localparam int DEF_OUTNEURON = 64;
   localparam int DEF_PI        = 4;
   localparam int DEF_PO        = 8;
   localparam int DEF_PIPE_LAT  = 3;
   localparam int DEF_BEAT_W    = 8;
   localparam int DEF_GRP_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RUN      = 3'd1,
      ST_DRAIN    = 3'd2,
      ST_WAIT_OUT = 3'd3,
      ST_DONE     = 3'd4
   } seq_state_t;

   // One slot of the accumulator strobe pipeline: beat present, and first beat of a group.
   typedef struct packed {
      logic vld;
      logic first;
   } beat_tag_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fc_seq_ctrl_param_2_if.sv
// Control/handshake bundle between the FC layer sequencer and its neighbours.
interface fc_seq_ctrl_param_2_if
   import fc_seq_ctrl_param_2_pkg::*;
#(
   parameter int GRP_W = DEF_GRP_W
) ();

   logic             start;
   logic             out_ready;
   logic             addr_en;
   logic             acc_clr;
   logic             acc_en;
   logic             out_valid;
   logic [GRP_W-1:0] group_idx;
   logic             busy;
   logic             done;

   modport master (
      input  start,
      input  out_ready,
      output addr_en,
      output acc_clr,
      output acc_en,
      output out_valid,
      output group_idx,
      output busy,
      output done
   );

   modport slave (
      output start,
      output out_ready,
      input  addr_en,
      input  acc_clr,
      input  acc_en,
      input  out_valid,
      input  group_idx,
      input  busy,
      input  done
   );

endinterface

// File: rtl/fc_delay_line_param_2.sv
// DEPTH-stage shift register carrying {valid, first} so MAC strobes line up with BRAM data.
// Fixed latency of DEPTH cycles; never stalls.
module fc_delay_line_param_2
   import fc_seq_ctrl_param_2_pkg::*;
#(
   parameter int DEPTH = DEF_PIPE_LAT
) (
   input  logic      clk,
   input  logic      reset,
   input  beat_tag_t beat,
   output beat_tag_t delayed
);

   beat_tag_t stage [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         // Qualify the marker with valid so the tail bit alone can drive acc_clr.
         stage[0] <= '{vld: beat.vld, first: beat.vld & beat.first};
         for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/fc_seq_ctrl_param_2.sv
// Layer-2 FC sequencer: one address sweep per output group, aligned MAC clear/enable strobes,
// and a valid/ready result handshake; holds out_valid until the writeback stage accepts.
module fc_seq_ctrl_param_2
   import fc_seq_ctrl_param_2_pkg::*;
#(
   parameter int INNEURON  = DEF_INNEURON,
   parameter int OUTNEURON = DEF_OUTNEURON,
   parameter int PI        = DEF_PI,
   parameter int PO        = DEF_PO,
   parameter int PIPE_LAT  = DEF_PIPE_LAT,
   parameter int BEAT_W    = DEF_BEAT_W,
   parameter int GRP_W     = DEF_GRP_W
) (
   input  logic                   clk,
   input  logic                   reset,
   fc_seq_ctrl_param_2_if.master  bus
);

   localparam int BEATS   = INNEURON / (2 * PI);
   localparam int GROUPS  = OUTNEURON / PO;
   localparam int DRAIN_W = cnt_width(PIPE_LAT);

   localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(BEATS - 1);
   localparam logic [GRP_W-1:0]   LAST_GRP   = GRP_W'(GROUPS - 1);
   localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

   if (INNEURON % (2 * PI) != 0) begin : g_bad_inneuron
      $error("INNEURON must be a multiple of 2*PI");
   end
   if (OUTNEURON % PO != 0) begin : g_bad_outneuron
      $error("OUTNEURON must be a multiple of PO");
   end
   if (BEATS < 1) begin : g_bad_beats
      $error("layer needs at least one beat per sweep");
   end
   if (PIPE_LAT < 1) begin : g_bad_pipe_lat
      $error("PIPE_LAT must be at least 1");
   end
   if (BEATS > (2 ** BEAT_W) || GROUPS > (2 ** GRP_W)) begin : g_bad_widths
      $error("BEAT_W/GRP_W too narrow for the layer geometry");
   end

   seq_state_t         state;
   logic [BEAT_W-1:0]  beat;
   logic [DRAIN_W-1:0] drain;
   logic [GRP_W-1:0]   grp;
   logic               addr_en;
   logic               addr_first;
   logic               out_valid;
   logic               busy;
   logic               done;
   beat_tag_t          tag_head;
   beat_tag_t          tag_tail;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         beat       <= '0;
         drain      <= '0;
         grp        <= '0;
         addr_en    <= 1'b0;
         addr_first <= 1'b0;
         out_valid  <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state      <= ST_RUN;
                  grp        <= '0;
                  beat       <= '0;
                  addr_en    <= 1'b1;
                  addr_first <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            ST_RUN: begin
               addr_first <= 1'b0;
               if (beat == LAST_BEAT) begin
                  // Ending on the generator's wrap point keeps it aligned for the next group.
                  addr_en <= 1'b0;
                  beat    <= '0;
                  drain   <= '0;
                  state   <= ST_DRAIN;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end

            ST_DRAIN: begin
               if (drain == LAST_DRAIN) begin
                  out_valid <= 1'b1;
                  state     <= ST_WAIT_OUT;
               end else begin
                  drain <= drain + DRAIN_W'(1);
               end
            end

            ST_WAIT_OUT: begin
               if (bus.out_ready) begin
                  out_valid <= 1'b0;
                  if (grp == LAST_GRP) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end else begin
                     grp        <= grp + GRP_W'(1);
                     beat       <= '0;
                     addr_en    <= 1'b1;
                     addr_first <= 1'b1;
                     state      <= ST_RUN;
                  end
               end
            end

            ST_DONE: begin
               grp   <= '0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign tag_head = '{vld: addr_en, first: addr_first};

   fc_delay_line_param_2 #(
      .DEPTH (PIPE_LAT)
   ) u_delay (
      .clk     (clk),
      .reset   (reset),
      .beat    (tag_head),
      .delayed (tag_tail)
   );

   assign bus.addr_en   = addr_en;
   assign bus.acc_en    = tag_tail.vld;
   assign bus.acc_clr   = tag_tail.first;
   assign bus.out_valid = out_valid;
   assign bus.group_idx = grp;
   assign bus.busy      = busy;
   assign bus.done      = done;

endmodule
